// File: rtl/clb_pkg.sv
// clb_pkg: FSM state type and per-BLE configuration field layout for the logic cluster
package clb_pkg;

    typedef enum logic {CFG_IDLE, CFG_LOAD} cfg_state_t;

    function automatic int ble_cfg_w(input int k);
        return (1 << k) + 2;
    endfunction

    function automatic int out_sel_bit(input int k);
        return 1 << k;
    endfunction

    function automatic int ff_init_bit(input int k);
        return (1 << k) + 1;
    endfunction

endpackage

// File: rtl/clb_ble.sv
// clb_ble: K-input LUT with optional registered output and load-time FF initialisation
module clb_ble
    import clb_pkg::*;
#(
    parameter int K = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ce,
    input  logic [K-1:0]          ble_in,
    input  logic [out_sel_bit(K):0] cfg,
    input  logic                  init,
    input  logic                  load_init,
    output logic                  ble_out
);

    localparam int LUT_W = 2**K;

    logic [LUT_W-1:0] tt;
    logic             lut;
    logic             ff;

    assign tt      = cfg[LUT_W-1:0];
    assign lut     = tt[ble_in];
    assign ble_out = cfg[out_sel_bit(K)] ? ff : lut;

    // a commit reloads the init value even when ce is high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ff <= 1'b0;
        else if (load_init) ff <= init;
        else if (ce) ff <= lut;
    end

endmodule

// File: rtl/clb_cluster.sv
// clb_cluster: N-BLE logic tile with a double-buffered serial configuration chain
module clb_cluster
    import clb_pkg::*;
#(
    parameter int K = 4,
    parameter int N = 4
) (
    input  logic           clb_clk,
    input  logic           clb_rst_n,
    input  logic [N*K-1:0] clb_input,
    input  logic           clb_ce,
    output logic [N-1:0]   clb_output,
    input  logic           cfg_start,
    input  logic           cfg_valid,
    input  logic           cfg_in,
    output logic           cfg_out,
    output logic           cfg_busy,
    output logic           cfg_done,
    output logic           cfg_ok
);

    localparam int LUT_W     = 2**K;
    localparam int BLE_CFG_W = ble_cfg_w(K);
    localparam int CFG_W     = N * BLE_CFG_W;
    localparam int CNT_W     = $clog2(CFG_W + 1);

    cfg_state_t             state;
    logic [CFG_W-1:0]       shadow;
    logic [CFG_W-1:0]       shift_nx;
    logic [N-1:0][LUT_W:0]  active;
    logic [CNT_W-1:0]       cnt;
    logic                   commit;
    logic [N-1:0]           ble_out;

    assign shift_nx   = {shadow[CFG_W-2:0], cfg_in};
    assign commit     = state == CFG_LOAD && cfg_valid && !cfg_start && cnt == CNT_W'(CFG_W - 1);
    assign cfg_busy   = state == CFG_LOAD;
    assign cfg_out    = shadow[CFG_W-1];
    assign clb_output = cfg_ok ? ble_out : '0;

    // ff_init is consumed at the commit edge only, so the active copy keeps table and out_sel
    always_ff @(posedge clb_clk or negedge clb_rst_n) begin
        if (!clb_rst_n) begin
            state    <= CFG_IDLE;
            shadow   <= '0;
            active   <= '0;
            cnt      <= '0;
            cfg_ok   <= 1'b0;
            cfg_done <= 1'b0;
        end else begin
            cfg_done <= commit;
            if (commit) begin
                for (int i = 0; i < N; i++) active[i] <= shift_nx[i*BLE_CFG_W +: LUT_W+1];
                shadow <= shift_nx;
                cfg_ok <= 1'b1;
                cnt    <= '0;
                state  <= CFG_IDLE;
            end else if (cfg_start) begin
                cnt   <= '0;
                state <= CFG_LOAD;
            end else if (state == CFG_LOAD && cfg_valid) begin
                shadow <= shift_nx;
                cnt    <= cnt + CNT_W'(1);
            end
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_ble
        clb_ble #(.K(K)) u_ble (
            .clk       (clb_clk),
            .rst_n     (clb_rst_n),
            .ce        (clb_ce),
            .ble_in    (clb_input[i*K +: K]),
            .cfg       (active[i]),
            .init      (shift_nx[i*BLE_CFG_W + ff_init_bit(K)]),
            .load_init (commit),
            .ble_out   (ble_out[i])
        );
    end

endmodule
